// File: rtl/led_trail_pwm_if.sv
// rtl/led_trail_pwm_if.sv - pattern input and PWM/status output bundle for led_trail_pwm
interface led_trail_pwm_if;
    logic [7:0] i_led_pattern;
    logic       i_pattern_valid;
    logic [7:0] o_led;
    logic       o_decay_tick;
    logic       o_active;

    modport master (
        output i_led_pattern,
        output i_pattern_valid,
        input  o_led,
        input  o_decay_tick,
        input  o_active
    );

    modport slave (
        input  i_led_pattern,
        input  i_pattern_valid,
        output o_led,
        output o_decay_tick,
        output o_active
    );
endinterface

// File: rtl/led_trail_pwm.sv
// rtl/led_trail_pwm.sv - per-LED decaying brightness trail with 16-step PWM drive
// Optional LED_GAMMA_EN maps brightness levels through a perceptual gamma table.
module led_trail_pwm #(
    parameter int unsigned DECAY_DIV = 1000
) (
    input  logic           i_clk,
    input  logic           i_rst,
    led_trail_pwm_if.slave bus
);
    localparam logic [15:0] PRESC_MAX = 16'(DECAY_DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic [3:0]  pwm_q, pwm_d;
    logic [3:0]  level_q [8];
    logic [3:0]  level_d [8];
    logic [7:0]  led_q, led_d;
    logic        tick_q, tick_d;
    logic        active_q, active_d;
    logic        decay_step;

    function automatic logic [3:0] cmp_val(input logic [3:0] lvl);
`ifdef LED_GAMMA_EN
        case (lvl)
            4'd0, 4'd1, 4'd2:  return 4'd0;
            4'd3, 4'd4, 4'd5:  return 4'd1;
            4'd6, 4'd7:        return 4'd2;
            4'd8:              return 4'd3;
            4'd9:              return 4'd4;
            4'd10:             return 4'd5;
            4'd11:             return 4'd6;
            4'd12:             return 4'd8;
            4'd13:             return 4'd10;
            4'd14:             return 4'd12;
            default:           return 4'd15;
        endcase
`else
        return lvl;
`endif
    endfunction

    always_comb begin
        decay_step = (presc_q == PRESC_MAX);
        presc_d    = decay_step ? 16'd0 : presc_q + 16'd1;
        pwm_d      = pwm_q + 4'd1;
        tick_d     = decay_step;
        active_d   = 1'b0;
        led_d      = 8'h00;
        for (int i = 0; i < 8; i++) begin
            // A load in the same cycle as a decay step takes priority.
            if (bus.i_pattern_valid && bus.i_led_pattern[i]) begin
                level_d[i] = 4'd15;
            end else if (decay_step && level_q[i] != 4'd0) begin
                level_d[i] = level_q[i] - 4'd1;
            end else begin
                level_d[i] = level_q[i];
            end
            led_d[i] = (cmp_val(level_q[i]) > pwm_q);
            active_d = active_d | (level_q[i] != 4'd0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc_q  <= 16'd0;
            pwm_q    <= 4'd0;
            led_q    <= 8'h00;
            tick_q   <= 1'b0;
            active_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                level_q[i] <= 4'd0;
            end
        end else begin
            presc_q  <= presc_d;
            pwm_q    <= pwm_d;
            led_q    <= led_d;
            tick_q   <= tick_d;
            active_q <= active_d;
            for (int i = 0; i < 8; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

    assign bus.o_led        = led_q;
    assign bus.o_decay_tick = tick_q;
    assign bus.o_active     = active_q;
endmodule

// File: tb/tb_led_trail_pwm.sv
// tb/tb_led_trail_pwm.sv - self-checking bench for led_trail_pwm with DECAY_DIV=4
module tb_led_trail_pwm;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_trail_pwm_if bus ();

    led_trail_pwm #(.DECAY_DIV(DIV)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] led;
        logic       tick;
        logic       act;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] p;
        logic [7:0] led;
        logic       tick;
        logic       act;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    int         m_presc;
    logic [3:0] m_pwm;
    logic [3:0] m_lev [8];

    logic [7:0] s_led;
    logic       s_tick;
    logic       s_act;

    function automatic logic [3:0] ref_cmp(input logic [3:0] l);
`ifdef LED_GAMMA_EN
        logic [3:0] g [16] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2,
                               4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd10, 4'd12, 4'd15};
        return g[l];
`else
        return l;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model predicts the registered outputs of the coming edge, then advances its state.
    task automatic step(input logic r, input logic v, input logic [7:0] p);
        exp_t e;
        exp_t got;
        logic dstep;
        rst = r;
        bus.i_pattern_valid = v;
        bus.i_led_pattern   = p;
        if (r) begin
            e = '{led: 8'h00, tick: 1'b0, act: 1'b0};
            m_presc = 0;
            m_pwm   = 4'd0;
            for (int i = 0; i < 8; i++) m_lev[i] = 4'd0;
        end else begin
            e.act  = 1'b0;
            e.tick = (m_presc == DIV - 1);
            for (int i = 0; i < 8; i++) begin
                e.led[i] = (ref_cmp(m_lev[i]) > m_pwm);
                if (m_lev[i] != 0) e.act = 1'b1;
            end
            dstep = (m_presc == DIV - 1);
            for (int i = 0; i < 8; i++) begin
                if (v && p[i]) m_lev[i] = 4'd15;
                else if (dstep && m_lev[i] != 0) m_lev[i] = m_lev[i] - 4'd1;
            end
            m_presc = dstep ? 0 : m_presc + 1;
            m_pwm   = m_pwm + 4'd1;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc_no++;
        s_led  = bus.o_led;
        s_tick = bus.o_decay_tick;
        s_act  = bus.o_active;
        got = sb_q.pop_front();
        checks++;
        if (s_led !== got.led || s_tick !== got.tick || s_act !== got.act) begin
            errors++;
            $display("FAIL scoreboard cycle %0d: led=%h tick=%b act=%b expected led=%h tick=%b act=%b",
                     cyc_no, s_led, s_tick, s_act, got.led, got.tick, got.act);
        end
    endtask

    vec_t tbl [15];
    int   n;
    int   ticks;
    int   tick_at;

    initial begin
        bus.i_pattern_valid = 1'b0;
        bus.i_led_pattern   = 8'h00;

        // Reset for 3 cycles, idle 8, load LED0, then watch first few cycles of its trail.
        for (int i = 0; i < 15; i++) tbl[i] = '{rst: 1'b0, v: 1'b0, p: 8'h00, led: 8'h00, tick: 1'b0, act: 1'b0};
        for (int i = 0; i < 3; i++) tbl[i].rst = 1'b1;
        tbl[6].tick  = 1'b1;
        tbl[10].tick = 1'b1;
        tbl[11].v = 1'b1;
        tbl[11].p = 8'h01;
        for (int i = 12; i < 15; i++) begin
            tbl[i].led = 8'h01;
            tbl[i].act = 1'b1;
        end
        tbl[14].tick = 1'b1;

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].p);
            chk($sformatf("tbl%0d_led", i), int'(s_led), int'(tbl[i].led));
            chk($sformatf("tbl%0d_tick", i), int'(s_tick), int'(tbl[i].tick));
            chk($sformatf("tbl%0d_act", i), int'(s_act), int'(tbl[i].act));
        end

        // Idle after reset: dark, inactive, tick every DIV cycles.
        repeat (3) step(1'b1, 1'b0, 8'h00);
        ticks = 0;
        n = 0;
        for (int i = 1; i <= 64; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (s_tick) ticks++;
            if (s_tick && (i % DIV) != 0) n++;
            if (s_led != 8'h00 || s_act) n++;
        end
        chk("idle_tick_count", ticks, 16);
        chk("idle_bad_cycles", n, 0);

        // Single load: active ends after 15 decay steps (60 cycles), one cycle later.
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h01);
        n = 0;
        ticks = 0;
        do begin
            step(1'b0, 1'b0, 8'h00);
            n++;
            if (s_tick) ticks++;
        end while (s_act && n < 200);
        chk("single_active_cycles", n, 60);
        chk("single_decay_ticks", ticks, 15);

        // Reload on a decay step at level 7 must restore 15, not 6.
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h04);
        repeat (34) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h04);
        n = 0;
        ticks = 0;
        do begin
            step(1'b0, 1'b0, 8'h00);
            n++;
            if (s_tick) ticks++;
        end while (s_act && n < 200);
        chk("reload_active_cycles", n, 61);
        chk("reload_decay_ticks", ticks, 15);

        // Chaser with interleaved empty valids.
        step(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, 8'(1 << k));
            repeat (3) step(1'b0, 1'b0, 8'h00);
            step(1'b0, 1'b1, 8'h00);
            repeat (3) step(1'b0, 1'b0, 8'h00);
        end
        chk("chaser_active", int'(s_act), 1);

        // One-cycle reset mid-trail clears everything; prescaler restarts.
        step(1'b1, 1'b1, 8'h80);
        chk("midrst_led", int'(s_led), 0);
        chk("midrst_act", int'(s_act), 0);
        chk("midrst_tick", int'(s_tick), 0);
        tick_at = 0;
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (s_tick && tick_at == 0) tick_at = i;
        end
        chk("midrst_first_tick", tick_at, DIV);
        chk("midrst_still_idle", int'(s_act), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
